// File: rtl/uart_rx_core_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_rx_core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int START_MID  = 7;
    localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_core_sync2.sv
// Two-flop synchronizer for the idle-high serial line; both stages reset to 1.
module rx_sync2 (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta_q, sync_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: 16 ticks per bit, start bit qualified at its
// midpoint, data sampled LSB first, one-cycle strobe when the stop ticks expire.
module uart_rx_core
    import uart_rx_core_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx,
    input  logic            i_s_tick,
    output logic            o_rx_done,
    output logic [DBIT-1:0] o_rx
);

    localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(START_MID);
    localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    logic            rx_s;
    rx_state_e       state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] data_q, data_d;
    logic            done_q, done_d;

    rx_sync2 u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // A tick landing on the falling-edge cycle is deliberately not counted.
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (i_s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (i_s_tick) begin
                    if (s_q == S_BIT) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) state_d = STOP;
                        else               n_d     = n_q + NW'(1);
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                // Stop level is not checked; the frame completes either way.
                if (i_s_tick) begin
                    if (s_q == S_STOP) begin
                        state_d = IDLE;
                        data_d  = b_q;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign o_rx      = data_q;
    assign o_rx_done = done_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed scoreboard bench for uart_rx_core: default 8N1 instance plus a DBIT=7/SB_TICK=32 instance.
module tb_uart_rx_core;
    import uart_rx_core_pkg::*;

    localparam int BIT_CYC = 432;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx7 = 1'b1;
    logic       tick = 1'b0;
    logic       done, done7;
    logic [7:0] dout;
    logic [6:0] dout7;

    uart_rx_core dut (
        .i_clk     (clk),
        .i_reset   (rst_n),
        .i_rx      (rx),
        .i_s_tick  (tick),
        .o_rx_done (done),
        .o_rx      (dout)
    );

    uart_rx_core #(.DBIT(7), .SB_TICK(32)) dut7 (
        .i_clk     (clk),
        .i_reset   (rst_n),
        .i_rx      (rx7),
        .i_s_tick  (tick),
        .o_rx_done (done7),
        .o_rx      (dout7)
    );

    always #5 clk = ~clk;

    int tcnt = 0;
    always @(posedge clk) begin
        tcnt <= (tcnt == 26) ? 0 : tcnt + 1;
        tick <= (tcnt == 26);
    end

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [6:0] got7_q[$];
    int         tick_total = 0;
    int         stamp7 = 0;

    always @(negedge clk) begin
        if (done)  got_q.push_back(dout);
        if (done7) begin
            got7_q.push_back(dout7);
            stamp7 <= tick_total;
        end
        if (tick) tick_total <= tick_total + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_tick();
        @(negedge clk);
        while (!tick) @(negedge clk);
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx7 = v;
        else     rx  = v;
    endtask

    // Drives one frame; align=0 starts immediately for back-to-back frames.
    task automatic send(input bit sel, input bit align, input logic [7:0] d, input int nb,
                        input logic stop_v, input int stop_cyc, output int mark);
        if (align) wait_tick();
        drive(sel, 1'b0);
        #1 mark = tick_total;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            drive(sel, d[i]);
            repeat (BIT_CYC) @(negedge clk);
        end
        drive(sel, stop_v);
        repeat (stop_cyc) @(negedge clk);
        drive(sel, 1'b1);
    endtask

    task automatic expect_frame(input string tag, output logic [7:0] g);
        int w = 0;
        g = '0;
        while (got_q.size() == 0 && w < 6000) begin
            @(negedge clk);
            w++;
        end
        if (got_q.size() == 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
        else begin
            g = got_q.pop_front();
            chk(tag, {24'd0, g}, {24'd0, exp_q.pop_front()});
        end
    endtask

    initial begin
        int         mark;
        int         w;
        logic [7:0] g0, g1;

        repeat (10) @(negedge clk);
        chk("rst_dout", {24'd0, dout}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dout7", {25'd0, dout7}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // 1: single 0x55
        exp_q.push_back(8'h55);
        send(1'b0, 1'b1, 8'h55, 8, 1'b1, BIT_CYC, mark);
        expect_frame("t1_55", g0);
        repeat (20 * 27) @(negedge clk);
        chk("t1_no_extra", got_q.size(), 32'd0);

        // 2: back-to-back 0xA3, 0x01 with zero gap
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h01);
        send(1'b0, 1'b1, 8'hA3, 8, 1'b1, BIT_CYC, mark);
        send(1'b0, 1'b0, 8'h01, 8, 1'b1, BIT_CYC, mark);
        expect_frame("t2_a3", g0);
        expect_frame("t2_01", g1);
        chk("t2_word", {16'd0, g1, g0}, 32'h0000_01A3);
        repeat (20 * 27) @(negedge clk);
        chk("t2_no_extra", got_q.size(), 32'd0);

        // 3: glitch of 3 ticks is a false start
        wait_tick();
        rx = 1'b0;
        repeat (3 * 27) @(negedge clk);
        rx = 1'b1;
        repeat (20 * 27) @(negedge clk);
        chk("t3_no_strobe", got_q.size(), 32'd0);
        chk("t3_state", {30'd0, dut.state_q}, {30'd0, IDLE});
        chk("t3_dout_hold", {24'd0, dout}, 32'h01);
        exp_q.push_back(8'h3C);
        send(1'b0, 1'b1, 8'h3C, 8, 1'b1, BIT_CYC, mark);
        expect_frame("t3_3c", g0);

        // 4: reset mid-way through 0xFF data bits
        wait_tick();
        rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        rx = 1'b1;
        repeat (4 * BIT_CYC + BIT_CYC / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_rst_dout", {24'd0, dout}, 32'd0);
        chk("t4_rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        repeat (6 * BIT_CYC) @(negedge clk);
        chk("t4_no_strobe", got_q.size(), 32'd0);
        exp_q.push_back(8'h81);
        send(1'b0, 1'b1, 8'h81, 8, 1'b1, BIT_CYC, mark);
        expect_frame("t4_81", g0);

        // 5: 0x00 with a low stop bit still completes
        exp_q.push_back(8'h00);
        send(1'b0, 1'b1, 8'h00, 8, 1'b0, 3 * BIT_CYC / 4, mark);
        expect_frame("t5_00", g0);
        repeat (30 * 27) @(negedge clk);
        chk("t5_no_extra", got_q.size(), 32'd0);
        chk("t5_state", {30'd0, dut.state_q}, {30'd0, IDLE});

        // 6: DBIT=7, two stop bits, strobe 152 ticks after the start edge
        send(1'b1, 1'b1, 8'h5A, 7, 1'b1, 2 * BIT_CYC, mark);
        w = 0;
        while (got7_q.size() == 0 && w < 6000) begin
            @(negedge clk);
            w++;
        end
        if (got7_q.size() == 0) chk("t6_timeout", 32'd0, 32'd1);
        else begin
            chk("t6_5a", {25'd0, got7_q.pop_front()}, 32'h5A);
            chk("t6_ticks", stamp7 - mark, 32'd152);
        end
        repeat (20 * 27) @(negedge clk);
        chk("t6_no_extra7", got7_q.size(), 32'd0);
        chk("t6_main_quiet", got_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
